// File: rtl/ariane_axi.sv
// AXI4 channel and bundle types shared by the cache miss handler and its memory responder.
package ariane_axi;

   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned IdWidth   = 4;
   localparam int unsigned StrbWidth = DataWidth / 8;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
   } aw_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
   } ar_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      logic                 last;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [1:0]         resp;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI4 slave backed by a word array; serves cache refills, write-backs and
// uncached beats. Define AXI_MEM_RESP_EXCL_EN to add a one-entry exclusive (LR/SC) monitor.
module axi_mem_responder #(
   parameter int unsigned                AXI_ADDR_WIDTH = 64,
   parameter int unsigned                AXI_DATA_WIDTH = 64,
   parameter int unsigned                AXI_ID_WIDTH   = 4,
   parameter type                        axi_req_t      = ariane_axi::req_t,
   parameter type                        axi_rsp_t      = ariane_axi::resp_t,
   parameter int unsigned                NumWords       = 1024,
   parameter logic [AXI_ADDR_WIDTH-1:0]  BaseAddr       = 64'h8000_0000
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  axi_req_t axi_req_i,
   output axi_rsp_t axi_resp_o,
   output logic     busy_o
);

   localparam int unsigned BeatBytes = AXI_DATA_WIDTH / 8;
   localparam int unsigned OffW      = $clog2(BeatBytes);
   localparam int unsigned IdxW      = $clog2(NumWords);

   localparam logic [AXI_ADDR_WIDTH-1:0] AxOne    = AXI_ADDR_WIDTH'(1);
   localparam logic [AXI_ADDR_WIDTH-1:0] MemBytes = AXI_ADDR_WIDTH'(NumWords * BeatBytes);
   localparam logic [AXI_ADDR_WIDTH-1:0] BeatMask = AXI_ADDR_WIDTH'(BeatBytes - 1);

   typedef enum logic [1:0] {StIdle, StWrite, StWresp, StRead} state_e;

   state_e state_q, state_d;

   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_next, wrap_mask, step, off;
   logic [7:0]                len_q, cnt_q;
   logic [2:0]                size_q;
   logic [1:0]                burst_q;
   logic                      err_q, wrap_err_q;

   logic aw_ready, ar_ready, w_ready, b_valid, r_valid;
   logic aw_hs, ar_hs, w_hs, r_hs;
   logic in_range, beat_ok, last_beat, mem_we;
   logic [IdxW-1:0]           idx;
   logic [AXI_DATA_WIDTH-1:0] rd_word;
   logic [1:0]                b_resp, r_resp;
   logic                      excl_drop, excl_wr_ok, excl_rd;

   logic [AXI_DATA_WIDTH-1:0] mem_q [NumWords];

   function automatic logic wrap_bad(input logic [1:0] burst, input logic [7:0] len);
      return (burst == ariane_axi::BurstWrap) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
   endfunction

   assign aw_hs = axi_req_i.aw_valid && aw_ready;
   assign ar_hs = axi_req_i.ar_valid && ar_ready;
   assign w_hs  = axi_req_i.w_valid && w_ready;
   assign r_hs  = axi_req_i.r_ready && r_valid;

   assign off       = addr_q - BaseAddr;
   assign in_range  = (addr_q >= BaseAddr) && (off < MemBytes);
   assign idx       = IdxW'(off >> OffW);
   assign beat_ok   = in_range && !wrap_err_q;
   assign rd_word   = beat_ok ? mem_q[idx] : '0;
   assign last_beat = (cnt_q == len_q);

   // WRAP keeps the upper bits of an aligned (len+1)*2**size window and wraps the low bits.
   assign step      = AxOne << size_q;
   assign wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + AxOne) << size_q) - AxOne;

   always_comb begin
      addr_next = addr_q + step;
      unique case (burst_q)
         ariane_axi::BurstFixed: addr_next = addr_q;
         ariane_axi::BurstWrap:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
         default:                addr_next = addr_q + step;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (aw_hs) begin
               state_d = StWrite;
            end else if (ar_hs) begin
               state_d = StRead;
            end
         end
         StWrite: if (w_hs && last_beat) state_d = StWresp;
         StWresp: if (axi_req_i.b_ready) state_d = StIdle;
         StRead:  if (r_hs && last_beat) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // AW wins a tie so a write-back lands before a refill of the same line.
   always_comb begin
      aw_ready = 1'b0;
      ar_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      r_valid  = 1'b0;
      if (!rst_i) begin
         unique case (state_q)
            StIdle: begin
               aw_ready = 1'b1;
               ar_ready = !axi_req_i.aw_valid;
            end
            StWrite: w_ready = 1'b1;
            StWresp: b_valid = 1'b1;
            StRead:  r_valid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         wrap_err_q <= 1'b0;
      end else if (aw_hs) begin
         id_q       <= axi_req_i.aw.id;
         addr_q     <= axi_req_i.aw.addr;
         len_q      <= axi_req_i.aw.len;
         size_q     <= axi_req_i.aw.size;
         burst_q    <= axi_req_i.aw.burst;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         wrap_err_q <= wrap_bad(axi_req_i.aw.burst, axi_req_i.aw.len);
      end else if (ar_hs) begin
         id_q       <= axi_req_i.ar.id;
         addr_q     <= axi_req_i.ar.addr;
         len_q      <= axi_req_i.ar.len;
         size_q     <= axi_req_i.ar.size;
         burst_q    <= axi_req_i.ar.burst;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         wrap_err_q <= wrap_bad(axi_req_i.ar.burst, axi_req_i.ar.len);
      end else if (w_hs || r_hs) begin
         addr_q <= addr_next;
         cnt_q  <= cnt_q + 8'd1;
         if (w_hs && (!in_range || (axi_req_i.w.last != last_beat))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign mem_we = w_hs && beat_ok && !excl_drop;

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < int'(BeatBytes); b++) begin
            if (axi_req_i.w.strb[b]) begin
               mem_q[idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
         end
      end
   end

`ifdef AXI_MEM_RESP_EXCL_EN
   logic                      mon_valid_q, excl_q, excl_ok_q;
   logic [AXI_ID_WIDTH-1:0]   mon_id_q;
   logic [AXI_ADDR_WIDTH-1:0] mon_addr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mon_valid_q <= 1'b0;
         mon_id_q    <= '0;
         mon_addr_q  <= '0;
         excl_q      <= 1'b0;
         excl_ok_q   <= 1'b0;
      end else if (aw_hs) begin
         excl_q    <= axi_req_i.aw.lock;
         excl_ok_q <= axi_req_i.aw.lock && mon_valid_q && (mon_id_q == axi_req_i.aw.id) &&
                      (mon_addr_q == (axi_req_i.aw.addr & ~BeatMask));
      end else if (ar_hs) begin
         excl_q    <= axi_req_i.ar.lock;
         excl_ok_q <= 1'b0;
         if (axi_req_i.ar.lock) begin
            mon_valid_q <= 1'b1;
            mon_id_q    <= axi_req_i.ar.id;
            mon_addr_q  <= axi_req_i.ar.addr & ~BeatMask;
         end
      end else if (w_hs) begin
         // A successful SC consumes the reservation; any plain store to the line breaks it.
         if (excl_q && excl_ok_q && last_beat) begin
            mon_valid_q <= 1'b0;
         end else if (!excl_q && beat_ok && ((addr_q & ~BeatMask) == mon_addr_q)) begin
            mon_valid_q <= 1'b0;
         end
      end
   end

   assign excl_drop  = excl_q && !excl_ok_q;
   assign excl_wr_ok = excl_q && excl_ok_q;
   assign excl_rd    = excl_q;

   logic unused_req;
   assign unused_req = ^{axi_req_i.aw.cache, axi_req_i.aw.prot,
                         axi_req_i.ar.cache, axi_req_i.ar.prot};
`else
   assign excl_drop  = 1'b0;
   assign excl_wr_ok = 1'b0;
   assign excl_rd    = 1'b0;

   logic unused_req;
   assign unused_req = ^{axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.lock,
                         axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.lock};
`endif

   always_comb begin
      b_resp = ariane_axi::RespOkay;
      if (err_q || wrap_err_q) begin
         b_resp = ariane_axi::RespSlverr;
      end else if (excl_wr_ok) begin
         b_resp = ariane_axi::RespExokay;
      end
      r_resp = ariane_axi::RespOkay;
      if (!beat_ok) begin
         r_resp = ariane_axi::RespSlverr;
      end else if (excl_rd) begin
         r_resp = ariane_axi::RespExokay;
      end
   end

   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.aw_ready = aw_ready;
      axi_resp_o.ar_ready = ar_ready;
      axi_resp_o.w_ready  = w_ready;
      axi_resp_o.b_valid  = b_valid;
      axi_resp_o.b.id     = id_q;
      axi_resp_o.b.resp   = b_resp;
      axi_resp_o.r_valid  = r_valid;
      axi_resp_o.r.id     = id_q;
      axi_resp_o.r.data   = rd_word;
      axi_resp_o.r.resp   = r_resp;
      axi_resp_o.r.last   = last_beat;
   end

   assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: refills, write-backs, arbitration, backpressure, errors.
module tb_axi_mem_responder;
   import ariane_axi::*;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   req_t  req;
   resp_t rsp;
   logic  busy;

   int checks = 0;
   int errors = 0;

   logic [63:0] wdata [16];
   logic [63:0] rdata [16];
   logic [1:0]  rresp [16];
   logic        rlast [16];
   logic [3:0]  rid   [16];
   int          rn;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .axi_req_i  (req),
      .axi_resp_o (rsp),
      .busy_o     (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int last_at, input logic lock, input int b_hold,
                            input bit with_ar);
      int n;
      @(negedge clk);
      req.aw       = '0;
      req.aw.addr  = addr;
      req.aw.len   = len;
      req.aw.size  = 3'd3;
      req.aw.burst = BurstIncr;
      req.aw.id    = id;
      req.aw.lock  = lock;
      req.aw_valid = 1'b1;
      if (with_ar) begin
         req.ar       = '0;
         req.ar.addr  = addr;
         req.ar.len   = len;
         req.ar.size  = 3'd3;
         req.ar.burst = BurstIncr;
         req.ar.id    = id + 4'd1;
         req.ar_valid = 1'b1;
      end
      #1;
      if (with_ar) begin
         check("arb_aw_ready", rsp.aw_ready, 1);
         check("arb_ar_ready", rsp.ar_ready, 0);
      end
      n = 0;
      while (!rsp.aw_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("aw_handshake", rsp.aw_ready, 1);
      @(negedge clk);
      req.aw_valid = 1'b0;
      #1;
      check("busy_write", busy, 1);
      for (int i = 0; i <= int'(len); i++) begin
         req.w.data  = wdata[i];
         req.w.strb  = '1;
         req.w.last  = (i == last_at);
         req.w_valid = 1'b1;
         #1;
         n = 0;
         while (!rsp.w_ready && n < 50) begin @(negedge clk); #1; n++; end
         @(negedge clk);
      end
      req.w_valid = 1'b0;
      req.w.last  = 1'b0;
      #1;
      n = 0;
      while (!rsp.b_valid && n < 50) begin @(negedge clk); #1; n++; end
      check("b_valid", rsp.b_valid, 1);
      for (int i = 0; i < b_hold; i++) begin
         @(negedge clk);
         #1;
         check("b_hold", rsp.b_valid, 1);
         if (with_ar) check("ar_blocked", rsp.ar_ready, 0);
      end
      bresp = rsp.b.resp;
      bid   = rsp.b.id;
      req.b_ready = 1'b1;
      @(posedge clk);
      #1;
      req.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input logic lock, input int stall_at);
      int          n;
      logic [63:0] hold_data;
      logic        hold_last;
      @(negedge clk);
      req.ar       = '0;
      req.ar.addr  = addr;
      req.ar.len   = len;
      req.ar.size  = 3'd3;
      req.ar.burst = burst;
      req.ar.id    = id;
      req.ar.lock  = lock;
      req.ar_valid = 1'b1;
      req.r_ready  = 1'b1;
      #1;
      n = 0;
      while (!rsp.ar_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("ar_handshake", rsp.ar_ready, 1);
      check("r_idle_before", rsp.r_valid, 0);
      @(negedge clk);
      req.ar_valid = 1'b0;
      #1;
      check("r_latency", rsp.r_valid, 1);
      rn = 0;
      while (rn <= int'(len)) begin
         n = 0;
         while (!rsp.r_valid && n < 50) begin @(negedge clk); #1; n++; end
         if (!rsp.r_valid) begin
            check("r_timeout", rsp.r_valid, 1);
            break;
         end
         if (rn == stall_at) begin
            req.r_ready = 1'b0;
            hold_data   = rsp.r.data;
            hold_last   = rsp.r.last;
            repeat (5) begin
               @(negedge clk);
               #1;
               check("stall_valid", rsp.r_valid, 1);
               check("stall_data", rsp.r.data, hold_data);
               check("stall_last", rsp.r.last, hold_last);
            end
            req.r_ready = 1'b1;
            #1;
         end
         rdata[rn] = rsp.r.data;
         rresp[rn] = rsp.r.resp;
         rlast[rn] = rsp.r.last;
         rid[rn]   = rsp.r.id;
         rn++;
         @(negedge clk);
         #1;
      end
      req.r_ready = 1'b0;
      check("r_done_idle", rsp.r_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [63:0] exp_refill [4];
      req = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_aw_ready", rsp.aw_ready, 0);
      check("rst_ar_ready", rsp.ar_ready, 0);
      check("rst_w_ready", rsp.w_ready, 0);
      check("rst_b_valid", rsp.b_valid, 0);
      check("rst_r_valid", rsp.r_valid, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_aw_ready", rsp.aw_ready, 1);
      check("idle_ar_ready", rsp.ar_ready, 1);

      // Preload words 0..3 with k*0x11, then a WRAP refill starting at word 2.
      for (int k = 0; k < 4; k++) wdata[k] = 64'(k * 'h11);
      axi_write(64'h8000_0000, 8'd3, 4'd1, 3, 1'b0, 0, 1'b0);
      check("preload_resp", bresp, RespOkay);
      check("preload_id", bid, 1);
      exp_refill[0] = 64'h22;
      exp_refill[1] = 64'h33;
      exp_refill[2] = 64'h00;
      exp_refill[3] = 64'h11;
      axi_read(64'h8000_0010, 8'd3, BurstWrap, 4'd5, 1'b0, -1);
      check("refill_beats", rn, 4);
      for (int i = 0; i < 4; i++) begin
         check("refill_data", rdata[i], exp_refill[i]);
         check("refill_last", rlast[i], (i == 3));
         check("refill_id", rid[i], 5);
         check("refill_resp", rresp[i], RespOkay);
      end

      // Write-back with B backpressure, read back with R backpressure mid-burst.
      for (int i = 0; i < 8; i++) wdata[i] = 64'(i);
      axi_write(64'h8000_0040, 8'd7, 4'd3, 7, 1'b0, 4, 1'b0);
      check("wb_resp", bresp, RespOkay);
      check("wb_id", bid, 3);
      axi_read(64'h8000_0040, 8'd7, BurstIncr, 4'd6, 1'b0, 3);
      check("wb_beats", rn, 8);
      for (int i = 0; i < 8; i++) check("wb_readback", rdata[i], 64'(i));
      check("wb_last", rlast[7], 1);

      // AW and AR to the same line together: the write must land first.
      for (int i = 0; i < 8; i++) wdata[i] = 64'hDEAD;
      axi_write(64'h8000_0080, 8'd7, 4'd2, 7, 1'b0, 0, 1'b0);
      for (int i = 0; i < 8; i++) wdata[i] = 64'h100 + 64'(i);
      axi_write(64'h8000_0080, 8'd7, 4'd4, 7, 1'b0, 2, 1'b1);
      check("arb_b_resp", bresp, RespOkay);
      axi_read(64'h8000_0080, 8'd7, BurstIncr, 4'd5, 1'b0, -1);
      for (int i = 0; i < 8; i++) check("arb_readback", rdata[i], 64'h100 + 64'(i));
      check("arb_r_id", rid[0], 5);

      // Below the base: single SLVERR beat with zero data.
      axi_read(64'h7FFF_FFF8, 8'd0, BurstIncr, 4'd7, 1'b0, -1);
      check("oor_beats", rn, 1);
      check("oor_data", rdata[0], 0);
      check("oor_resp", rresp[0], RespSlverr);
      check("oor_last", rlast[0], 1);

      // w.last on beat 2 of a 4-beat burst.
      axi_write(64'h8000_0200, 8'd3, 4'd2, 1, 1'b0, 0, 1'b0);
      check("early_last_resp", bresp, RespSlverr);

      // Burst straddling the top word: second beat is out of range.
      wdata[0] = 64'h1234;
      wdata[1] = 64'h5678;
      axi_write(64'h8000_1FF8, 8'd1, 4'd1, 1, 1'b0, 0, 1'b0);
      check("top_wr_resp", bresp, RespSlverr);
      axi_read(64'h8000_1FF8, 8'd1, BurstIncr, 4'd1, 1'b0, -1);
      check("top_rd_data0", rdata[0], 64'h1234);
      check("top_rd_resp0", rresp[0], RespOkay);
      check("top_rd_data1", rdata[1], 0);
      check("top_rd_resp1", rresp[1], RespSlverr);

      // WRAP with len=2 is illegal for the whole burst.
      axi_read(64'h8000_0000, 8'd2, BurstWrap, 4'd1, 1'b0, -1);
      check("badwrap_beats", rn, 3);
      check("badwrap_resp", rresp[0], RespSlverr);
      check("badwrap_data", rdata[0], 0);

`ifdef AXI_MEM_RESP_EXCL_EN
      axi_read(64'h8000_0100, 8'd0, BurstIncr, 4'd2, 1'b1, -1);
      check("lr1_resp", rresp[0], RespExokay);
      wdata[0] = 64'h55;
      axi_write(64'h8000_0100, 8'd0, 4'd2, 0, 1'b0, 0, 1'b0);
      check("plain_wr_resp", bresp, RespOkay);
      wdata[0] = 64'h77;
      axi_write(64'h8000_0100, 8'd0, 4'd2, 0, 1'b1, 0, 1'b0);
      check("sc_fail_resp", bresp, RespOkay);
      axi_read(64'h8000_0100, 8'd0, BurstIncr, 4'd2, 1'b0, -1);
      check("sc_fail_mem", rdata[0], 64'h55);
      check("plain_rd_resp", rresp[0], RespOkay);
      axi_read(64'h8000_0100, 8'd0, BurstIncr, 4'd2, 1'b1, -1);
      check("lr2_resp", rresp[0], RespExokay);
      wdata[0] = 64'h99;
      axi_write(64'h8000_0100, 8'd0, 4'd2, 0, 1'b1, 0, 1'b0);
      check("sc_ok_resp", bresp, RespExokay);
      axi_read(64'h8000_0100, 8'd0, BurstIncr, 4'd2, 1'b0, -1);
      check("sc_ok_mem", rdata[0], 64'h99);
`else
      axi_read(64'h8000_0100, 8'd0, BurstIncr, 4'd2, 1'b1, -1);
      check("lock_rd_resp", rresp[0], RespOkay);
      wdata[0] = 64'h77;
      axi_write(64'h8000_0100, 8'd0, 4'd2, 0, 1'b1, 0, 1'b0);
      check("lock_wr_resp", bresp, RespOkay);
      axi_read(64'h8000_0100, 8'd0, BurstIncr, 4'd2, 1'b0, -1);
      check("lock_wr_mem", rdata[0], 64'h77);
`endif

      check("final_idle", busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
